// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the multi-cycle ALU and the control unit.
// No logic; constants and types only.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_NAND = 3'b111;

    localparam int MIN_DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// Latency DATA_W cycles after start; lo/hi show the step result, final when done is high.
// No backpressure: the caller must capture lo/hi on the cycle done is asserted.
module alu_iter_muldiv #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W-1:0] opnd;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              div_q;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;
    logic              div_ge;
    logic [DATA_W-1:0] nxt_hi;
    logic [DATA_W-1:0] nxt_lo;

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide keeps the dividend in acc_lo and shifts quotient bits in from the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (div_q) begin
            nxt_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            nxt_lo = {acc_lo[DATA_W-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[DATA_W:1];
            nxt_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt == CNT_W'(DATA_W - 1));
    assign lo   = nxt_lo;
    assign hi   = nxt_hi;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (start) begin
            acc_hi <= '0;
            acc_lo <= is_div ? a : b;
            opnd   <= is_div ? b : a;
            cnt    <= '0;
            busy_q <= 1'b1;
            div_q  <= is_div;
        end else if (busy_q) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (done) begin
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes; MUL/DIV run on the iterative engine.
// Latency 1 cycle for logic/ADD/SUB/DIV-by-zero, DATA_W+1 cycles for MUL and DIV.
// Holds results frozen in DONE until out_ready; in_ready only in IDLE.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              zero,
    output logic              carry,
    output logic              parity,
    output logic              overflow,
    output logic              div_by_zero
);

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              op_mul;
    logic              op_div;
    logic              b_zero;
    logic              iter_start;
    logic              iter_busy;
    logic              iter_done;
    logic [DATA_W-1:0] iter_lo;
    logic [DATA_W-1:0] iter_hi;

    logic [DATA_W:0]   add_w;
    logic [DATA_W:0]   sub_w;
    logic [DATA_W-1:0] sc_res;
    logic [DATA_W-1:0] sc_hi;
    logic              sc_carry;
    logic              sc_ovf;
    logic              sc_dbz;

    assign accept     = in_valid && in_ready;
    assign op_mul     = (opcode == OP_MUL);
    assign op_div     = (opcode == OP_DIV);
    assign b_zero     = (b == '0);
    assign iter_start = accept && (op_mul || (op_div && !b_zero));

    alu_iter_muldiv #(.DATA_W(DATA_W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (iter_start),
        .is_div (op_div),
        .a      (a),
        .b      (b),
        .busy   (iter_busy),
        .done   (iter_done),
        .lo     (iter_lo),
        .hi     (iter_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op_mul)                state_nxt = ST_MUL;
                    else if (op_div && !b_zero) state_nxt = ST_DIV;
                    else                       state_nxt = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: begin
                // An idle engine here can only mean lost sync; fall back rather than hang.
                if (iter_done)       state_nxt = ST_DONE;
                else if (!iter_busy) state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) && rst;
        out_valid = (state == ST_DONE);
    end

    always_comb begin
        add_w    = {1'b0, a} + {1'b0, b};
        sub_w    = {1'b0, a} - {1'b0, b};
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dbz   = 1'b0;
        case (opcode)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_NOR:  sc_res = ~(a | b);
            OP_NAND: sc_res = ~(a & b);
            OP_ADD: begin
                sc_res   = add_w[DATA_W-1:0];
                sc_carry = add_w[DATA_W];
                sc_ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (add_w[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                sc_res   = sub_w[DATA_W-1:0];
                sc_carry = sub_w[DATA_W];
                sc_ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (sub_w[DATA_W-1] != a[DATA_W-1]);
            end
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = a;
                sc_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            parity      <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept && !iter_start) begin
            result      <= sc_res;
            result_hi   <= sc_hi;
            zero        <= ({sc_hi, sc_res} == '0);
            carry       <= sc_carry;
            parity      <= ~^sc_res;
            overflow    <= sc_ovf;
            div_by_zero <= sc_dbz;
        end else if (iter_done) begin
            result      <= iter_lo;
            result_hi   <= iter_hi;
            zero        <= ({iter_hi, iter_lo} == '0);
            carry       <= (state == ST_MUL) && (iter_hi != '0);
            parity      <= ~^iter_lo;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at DATA_W=16: directed cases, backpressure, reset abort, random ops.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         carry;
    logic         parity;
    logic         overflow;
    logic         div_by_zero;

    always #5 clk = ~clk;

    alu_multicycle #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .carry       (carry),
        .parity      (parity),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         p;
        logic         o;
        logic         d;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          sx;
        int          sy;
        int          sr;
        logic [31:0] p;
        sx    = int'($signed(x));
        sy    = int'($signed(y));
        e.res = '0;
        e.hi  = '0;
        e.c   = 1'b0;
        e.o   = 1'b0;
        e.d   = 1'b0;
        e.lat = 1;
        case (op)
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_NOR:  e.res = ~(x | y);
            OP_NAND: e.res = ~(x & y);
            OP_ADD: begin
                p     = 32'(x) + 32'(y);
                e.res = p[W-1:0];
                e.c   = (p > 32'hFFFF);
                sr    = sx + sy;
                e.o   = (sr > 32767) || (sr < -32768);
            end
            OP_SUB: begin
                e.res = x - y;
                e.c   = (x < y);
                sr    = sx - sy;
                e.o   = (sr > 32767) || (sr < -32768);
            end
            OP_MUL: begin
                p     = 32'(x) * 32'(y);
                e.res = p[15:0];
                e.hi  = p[31:16];
                e.c   = (p[31:16] != 16'h0);
                e.lat = 17;
            end
            default: begin
                if (y == '0) begin
                    e.res = 16'hFFFF;
                    e.hi  = x;
                    e.d   = 1'b1;
                end else begin
                    e.res = x / y;
                    e.hi  = x % y;
                    e.lat = 17;
                end
            end
        endcase
        e.z = ({e.hi, e.res} == 32'h0);
        e.p = ~^e.res;
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check_eq("issue.in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        opcode   = op;
        a        = x;
        b        = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode   = 3'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   lat;
        logic rdy_seen;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
        e = exp_q.pop_front();
        check_eq({tag, ".latency"}, lat, e.lat);
        check_eq({tag, ".result"}, result, e.res);
        check_eq({tag, ".result_hi"}, result_hi, e.hi);
        check_eq({tag, ".flags_zcpod"}, {zero, carry, parity, overflow, div_by_zero},
                 {e.z, e.c, e.p, e.o, e.d});
        check_eq({tag, ".in_ready_busy"}, rdy_seen, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_q.push_back(model(op, x, y));
        issue(op, x, y);
        collect(tag);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".hs_out_valid"}, out_valid, 0);
        check_eq({tag, ".hs_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.out_valid", out_valid, 0);
        check_eq("rst.in_ready", in_ready, 0);
        check_eq("rst.data", {result_hi, result}, 0);
        check_eq("rst.flags", {zero, carry, parity, overflow, div_by_zero}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst.release_in_ready", in_ready, 1);

        run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001);  handshake("add_wrap");
        run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001);   handshake("sub_ovf");
        run_op("sub_borrow", OP_SUB, 16'h0001, 16'h0002); handshake("sub_borrow");
        run_op("mul", OP_MUL, 16'h1234, 16'h0100);       handshake("mul");
        run_op("div", OP_DIV, 16'd1000, 16'd7);          handshake("div");
        run_op("div0", OP_DIV, 16'h00AB, 16'h0000);      handshake("div0");
        run_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF);   handshake("mul_max");
        run_op("div_by1", OP_DIV, 16'hFFFF, 16'h0001);   handshake("div_by1");
        run_op("div_small", OP_DIV, 16'h0003, 16'h0009); handshake("div_small");
        run_op("nand", OP_NAND, 16'hF0F0, 16'hFF00);     handshake("nand");

        // Backpressure: outputs frozen and new requests refused while out_ready is low.
        run_op("bp_add", OP_ADD, 16'h1234, 16'h0101);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            opcode   = OP_SUB;
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk); #1;
            check_eq("bp.out_valid", out_valid, 1);
            check_eq("bp.in_ready", in_ready, 0);
            check_eq("bp.result", result, 16'h1335);
        end
        in_valid = 1'b0;
        handshake("bp");
        @(posedge clk); #1;
        check_eq("bp.no_accept", out_valid, 0);

        // Reset lands on the edge of MUL iteration 8.
        issue(OP_MUL, 16'h1234, 16'h5678);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("abort.out_valid", out_valid, 0);
        check_eq("abort.in_ready", in_ready, 0);
        check_eq("abort.data", {result_hi, result}, 0);
        check_eq("abort.flags", {zero, carry, parity, overflow, div_by_zero}, 0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("abort.no_partial", out_valid, 0);
        end
        check_eq("abort.idle", in_ready, 1);
        run_op("mul_after_abort", OP_MUL, 16'h0003, 16'h0005); handshake("mul_after_abort");

        // Random ops with out_ready held high ahead of the result.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [2:0]   op;
            logic [W-1:0] x;
            logic [W-1:0] y;
            op = 3'($urandom);
            x  = W'($urandom);
            y  = (i % 4 == 3) ? W'(0) : W'($urandom_range(0, 300));
            exp_q.push_back(model(op, x, y));
            issue(op, x, y);
            out_ready = 1'b1;
            collect("rand");
            @(posedge clk); #1;
            check_eq("rand.auto_hs", out_valid, 0);
        end
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle ALU that replaces the single-cycle combinational ALU in the mini CPU datapath. It keeps the existing 3-bit opcode map and the parity, carry and zero flags. It adds:
- a DATA_W parameter;
- iterative shift-add multiply and restoring divide, producing a full-width product high word and a remainder;
- signed-overflow and divide-by-zero flags;
- valid/ready handshakes on input and output.

The control unit issues one operation per handshake and stalls on out_valid.

## Interface
- DATA_W, default 16: operand and result width, minimum 4.
- clk  in  1: sole clock, rising edge.
- rst  in  1: synchronous, active-low reset.
- in_valid  in  1: operation request.
- in_ready  out  1: block can accept a request.
- opcode  in  3: 000 AND, 001 ADD, 010 MUL, 011 DIV, 100 OR, 101 SUB, 110 NOR, 111 NAND.
- a, b  in  DATA_W: unsigned operands.
- out_valid  out  1: result and flags valid.
- out_ready  in  1: consumer accepts the result.
- result  out  DATA_W: low word or quotient.
- result_hi  out  DATA_W: MUL high word, DIV remainder, 0 for all other opcodes.
- zero, carry, parity, overflow, div_by_zero  out  1 each: status flags.

## Operation
- States: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE) && rst.
- Accept: in_valid && in_ready at a rising edge. opcode, a and b are captured on that edge. Input changes after acceptance are ignored. in_valid outside IDLE is ignored.
- Single-cycle ops (AND, OR, NOR, NAND, ADD, SUB): the output registers load at the accept edge, then IDLE→DONE.
- MUL: IDLE→MUL. A DATA_W-iteration shift-add runs on a 2·DATA_W product, with an iteration counter from 0 to DATA_W-1. The last iteration's edge moves to DONE and loads the output registers.
- DIV with b≠0: IDLE→DIV. DATA_W-iteration restoring division, one quotient bit per cycle, MSB first. Then DONE.
- DIV with b==0: IDLE→DONE directly, with result = all ones, result_hi = a, div_by_zero = 1.
- DONE: out_valid = 1 and all outputs stay stable until out_valid && out_ready. On that edge the block returns to IDLE, out_valid drops and in_ready rises.
- Flags:
  - zero = 1 when {result_hi, result} == 0.
  - parity = ~^result, so 1 for even parity.
  - carry: ADD gives carry-out bit DATA_W. SUB gives the borrow (a<b). MUL gives result_hi≠0. All other opcodes give 0.
  - overflow: signed two's-complement overflow for ADD/SUB, 0 otherwise.
  - div_by_zero: 1 only as described above.
- Widths: ADD/SUB are computed at DATA_W+1 bits. The product is 2·DATA_W bits. Quotient and remainder are DATA_W bits each.

## Timing
- Reset (rst==0 at an edge):
  - state goes to IDLE;
  - all outputs go to 0, including out_valid and every flag;
  - the iteration counter clears;
  - in_ready reads 0 while rst is low and 1 in the first cycle after release.
- Reset mid-MUL, mid-DIV or in DONE aborts the operation. No partial result is ever presented.
- Latency is measured from the accept edge to out_valid being visible:
  - single-cycle ops: 1 cycle;
  - DIV by zero: 1 cycle;
  - MUL and DIV: DATA_W+1 cycles (17 at the default).
- Throughput: at most one operation per 2 cycles. There is no accept in the same cycle as an output handshake.
- out_ready held high before the result arrives: the handshake completes on the first DONE edge.
- out_ready held low: the block stalls indefinitely in DONE with outputs frozen.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_AND through OP_NAND;
  - the state encoding for IDLE, MUL, DIV and DONE.
- The control unit imports the same opcode constants.
- One sub-module, alu_iter_muldiv, holds the shared shift register, the iteration counter and the per-cycle add/subtract step.
  - Ports: start, is_div, a, b, busy, done, lo, hi.
  - The top module holds the FSM, the single-cycle datapath, flag logic and output registers.

## Test plan
All scenarios use DATA_W=16.
- ADD 0xFFFF+0x0001 → result 0x0000, carry 1, zero 1, overflow 0, parity 1. out_valid is seen 1 cycle after accept.
- SUB 0x8000-0x0001 → result 0x7FFF, overflow 1, carry 0, parity 0. A second case, SUB 0x0001-0x0002, gives 0xFFFF with carry 1.
- MUL 0x1234×0x0100 → result 0x3400, result_hi 0x0012, carry 1. out_valid is seen exactly 17 cycles after accept, and in_ready stays 0 throughout.
- DIV 1000÷7 → result 0x008E, result_hi 0x0006, latency 17. DIV 0x00AB÷0 → result 0xFFFF, result_hi 0x00AB, div_by_zero 1, latency 1.
- Backpressure: after an ADD completes, hold out_ready=0 for 5 cycles while pulsing in_valid with new operands. Outputs stay unchanged, in_ready stays 0, and the new request is not accepted. Releasing out_ready gives a handshake, then in_ready=1 the next cycle.
- Drive rst=0 during MUL iteration 8. On the next edge all outputs are 0 and the state is IDLE. After release, MUL 0x0003×0x0005 → result 0x000F, result_hi 0, carry 0.
